// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizes, word/beat types and
// the skid-buffer occupancy encoding used by the read-side drain.
package fifo_pkg;

   localparam int WIDTH_DEF   = 128;
   localparam int DEPTH_DEF   = 1024;
   localparam int ADDRESS_DEF = 10;

   typedef logic [WIDTH_DEF-1:0] fifo_word_t;

   typedef struct {
      fifo_word_t data;
      logic       last;
   } stream_beat_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   // True when the buffer still has a free slot for a read issued now,
   // counting the beat already in flight and the pop happening this cycle.
   function automatic logic has_room(
      input logic [1:0] occ,
      input logic       inflight,
      input logic       pop
   );
      logic [2:0] lvl;
      lvl = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      return lvl < 3'd2;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry skid buffer; entry 0 is the
// registered head that drives the stream outputs.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int W = WIDTH_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         push_last,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         head_last,
   output logic [1:0]   occ
);

   occ_t         state;
   occ_t         state_nx;
   logic [W-1:0] d0;
   logic [W-1:0] d0_nx;
   logic [W-1:0] d1;
   logic [W-1:0] d1_nx;
   logic         l0;
   logic         l0_nx;
   logic         l1;
   logic         l1_nx;

   assign head_data = d0;
   assign head_last = l0;
   assign occ       = state;

   // Occupancy state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= OCC_EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   // Entry storage; cleared on reset so the head reads zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d0 <= '0;
         l0 <= 1'b0;
         d1 <= '0;
         l1 <= 1'b0;
      end else begin
         d0 <= d0_nx;
         l0 <= l0_nx;
         d1 <= d1_nx;
         l1 <= l1_nx;
      end
   end

   // Next occupancy and entry contents from push/pop
   always_comb begin
      state_nx = state;
      d0_nx    = d0;
      l0_nx    = l0;
      d1_nx    = d1;
      l1_nx    = l1;
      unique case (state)
         OCC_EMPTY: begin
            if (push) begin
               d0_nx    = push_data;
               l0_nx    = push_last;
               state_nx = OCC_ONE;
            end
         end
         OCC_ONE: begin
            unique case (1'b1)
               (push && pop): begin
                  d0_nx = push_data;
                  l0_nx = push_last;
               end
               (push && !pop): begin
                  d1_nx    = push_data;
                  l1_nx    = push_last;
                  state_nx = OCC_TWO;
               end
               (!push && pop): begin
                  state_nx = OCC_EMPTY;
               end
               default: begin
                  state_nx = OCC_ONE;
               end
            endcase
         end
         OCC_TWO: begin
            if (pop) begin
               d0_nx = d1;
               l0_nx = l1;
               if (push) begin
                  d1_nx = push_data;
                  l1_nx = push_last;
               end else begin
                  state_nx = OCC_ONE;
               end
            end
         end
         default: begin
            state_nx = OCC_EMPTY;
         end
      endcase
   end

endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: issues FIFO reads, captures data, frames packets, streams out.
// Optional stats outputs (beats_total, stall_cycles) under FIFO_STREAM_DRAIN_STATS_EN.
module fifo_stream_drain
   import fifo_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int PKT_LEN = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             busy
`ifdef FIFO_STREAM_DRAIN_STATS_EN
   ,
   output logic [31:0]      beats_total,
   output logic [31:0]      stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

   logic             pop;
   logic             inflight;
   logic             cap_last;
   logic [1:0]       occ;
   logic [CNT_W-1:0] beat_cnt;

   assign pop      = m_valid && m_ready;
   assign m_valid  = (occ != 2'd0);
   assign cap_last = (beat_cnt == LAST_CNT);
   assign busy     = m_valid || inflight;

   // Reads are held off in reset and whenever the buffer could overflow
   assign fifo_rd = reset_n && en && !fifo_empty
                    && has_room(occ, inflight, pop);

   // A read accepted this cycle returns data on the next cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd && !fifo_empty;
      end
   end

   // Beat position within the packet, advanced per captured beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
      end else if (inflight) begin
         beat_cnt <= cap_last ? '0 : beat_cnt + CNT_W'(1);
      end
   end

   fifo_skid_buf #(
      .W (WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (inflight),
      .push_data (fifo_data),
      .push_last (cap_last),
      .pop       (pop),
      .head_data (m_data),
      .head_last (m_last),
      .occ       (occ)
   );

`ifdef FIFO_STREAM_DRAIN_STATS_EN
   // Saturating counters of delivered beats and stalled cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beats_total  <= '0;
         stall_cycles <= '0;
      end else begin
         if (pop && (beats_total != 32'hFFFF_FFFF)) begin
            beats_total <= beats_total + 32'd1;
         end
         if (m_valid && !m_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: table vectors, hand sequences and random traffic
// checked against an in-order model of the words written into the FIFO.
`timescale 1ns/1ps
module tb_fifo_stream_drain;
   import fifo_pkg::*;

   localparam int W     = WIDTH_DEF;
   localparam int PKT   = 4;
   localparam int MEM_N = 8192;

   typedef struct {
      logic en;
      logic rdy;
      logic e_rd;
      logic e_valid;
      int   e_idx;
      logic e_last;
      logic e_busy;
   } vec_t;

   logic         clk       = 1'b0;
   logic         reset_n   = 1'b0;
   logic         en        = 1'b0;
   logic         m_ready   = 1'b0;
   logic [W-1:0] fifo_data = '0;
   logic         fifo_empty;
   logic         fifo_rd;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_last;
   logic         busy;
`ifdef FIFO_STREAM_DRAIN_STATS_EN
   logic [31:0]  beats_total;
   logic [31:0]  stall_cycles;
`endif

   fifo_word_t mem [MEM_N];
   int         wp = 0;
   int         rp = 0;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         out_idx = 0;
   int         beat_no = 0;
   int         pops    = 0;
   int         stalls  = 0;
   int         rd_count  = 0;
   int         pop_count = 0;
   logic       stall_prev = 1'b0;
   logic       rd_prev    = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic       prev_last  = 1'b0;
   logic       last_hist [16];
   vec_t       tv [7];

   fifo_stream_drain #(
      .WIDTH   (W),
      .PKT_LEN (PKT),
      .CNT_W   (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_rd      (fifo_rd),
      .fifo_data    (fifo_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .busy         (busy)
`ifdef FIFO_STREAM_DRAIN_STATS_EN
      ,
      .beats_total  (beats_total),
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rp == wp);

   // Synchronous FIFO read port: registered data after an accepted read
   always @(posedge clk) begin
      if (fifo_rd && !fifo_empty) begin
         fifo_data <= mem[rp];
         rp <= rp + 1;
      end
   end

   task automatic check_b(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic check_i(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_w(input string nm, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic stream_beat_t exp_beat(input int idx, input int bn);
      stream_beat_t b;
      b.data = mem[idx % MEM_N];
      b.last = ((bn % PKT) == PKT - 1);
      return b;
   endfunction

   task automatic push_word();
      mem[wp] = {$urandom, $urandom, $urandom, $urandom};
      wp++;
   endtask

   // Per-cycle stream checks, sampled at the falling edge
   task automatic mon();
      stream_beat_t eb;
      if (!reset_n) begin
         out_idx    = rp;
         beat_no    = 0;
         stall_prev = 1'b0;
         rd_prev    = 1'b0;
         pops       = 0;
         stalls     = 0;
         return;
      end
`ifdef FIFO_STREAM_DRAIN_STATS_EN
      check_i("stat_beats", int'(beats_total), pops);
      check_i("stat_stalls", int'(stall_cycles), stalls);
`endif
      check_b("busy", busy, m_valid || rd_prev);
      if (fifo_rd) begin
         rd_count++;
         check_b("rd_while_en_low", en, 1'b1);
         check_b("rd_while_empty", fifo_empty, 1'b0);
      end
      if (stall_prev) begin
         check_b("hold_valid", m_valid, 1'b1);
         check_w("hold_data", m_data, prev_data);
         check_b("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
         eb = exp_beat(out_idx, beat_no);
         check_b("pop_was_read", out_idx < rp, 1'b1);
         check_w("pop_data", m_data, eb.data);
         check_b("pop_last", m_last, eb.last);
         if (pop_count < 16) last_hist[pop_count] = m_last;
         out_idx++;
         beat_no++;
         pops++;
         pop_count++;
      end
      if (m_valid && !m_ready) stalls++;
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      rd_prev    = fifo_rd && !fifo_empty;
   endtask

   task automatic cyc_check();
      @(negedge clk);
      mon();
   endtask

   task automatic cyc_adv();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_check();
         cyc_adv();
      end
   endtask

   task automatic drain(input int lim);
      int k = 0;
      en      = 1'b1;
      m_ready = 1'b1;
      while (k < lim && (out_idx != wp || busy)) begin
         cyc_check();
         cyc_adv();
         k++;
      end
      check_i("drain_all_beats", out_idx, wp);
      check_b("drain_idle", busy, 1'b0);
   endtask

   initial begin
      int base;

      tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1};
      tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1};
      tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1};
      tv[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1};
      tv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1};
      tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};

      // Reset with four words waiting and reads enabled
      en      = 1'b1;
      m_ready = 1'b1;
      base    = wp;
      for (int i = 0; i < 4; i++) push_word();
      cyc_check();
      check_b("rst_fifo_rd", fifo_rd, 1'b0);
      check_b("rst_m_valid", m_valid, 1'b0);
      check_w("rst_m_data", m_data, '0);
      check_b("rst_m_last", m_last, 1'b0);
      check_b("rst_busy", busy, 1'b0);
      cyc_adv();
      reset_n = 1'b1;

      // Cycle-exact startup: 2-cycle read-to-valid, one beat per cycle
      for (int i = 0; i < 7; i++) begin
         en      = tv[i].en;
         m_ready = tv[i].rdy;
         cyc_check();
         check_b($sformatf("tv%0d_rd", i), fifo_rd, tv[i].e_rd);
         check_b($sformatf("tv%0d_valid", i), m_valid, tv[i].e_valid);
         check_b($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
         if (tv[i].e_valid) begin
            check_w($sformatf("tv%0d_data", i), m_data, mem[base + tv[i].e_idx]);
            check_b($sformatf("tv%0d_last", i), m_last, tv[i].e_last);
         end
         cyc_adv();
      end
      drain(20);

      // Backpressure: only two reads outstanding, head held
      m_ready = 1'b0;
      base    = wp;
      for (int i = 0; i < 10; i++) push_word();
      rd_count = 0;
      step(8);
      check_i("bp_rd_count", rd_count, 2);
      check_b("bp_valid", m_valid, 1'b1);
      check_w("bp_head", m_data, mem[base]);
      check_i("bp_none_popped", out_idx, base);
      drain(60);

      // en dropped right after a read was issued
      for (int i = 0; i < 12; i++) push_word();
      en = 1'b1;
      m_ready = 1'b1;
      step(4);
      en = 1'b0;
      rd_count  = 0;
      pop_count = 0;
      step(5);
      check_i("en_off_no_rd", rd_count, 0);
      check_b("en_off_popped", pop_count > 0, 1'b1);
      check_i("en_off_delivered", out_idx, rp);
      drain(60);

      // Asynchronous reset mid-stream, then framing from a fresh count
      for (int i = 0; i < 20; i++) push_word();
      step(5);
      #2 reset_n = 1'b0;
      #1;
      check_b("mid_rst_valid", m_valid, 1'b0);
      check_w("mid_rst_data", m_data, '0);
      check_b("mid_rst_last", m_last, 1'b0);
      check_b("mid_rst_busy", busy, 1'b0);
      check_b("mid_rst_rd", fifo_rd, 1'b0);
      step(1);
      wp = rp;
      for (int i = 0; i < 9; i++) push_word();
      step(1);
      pop_count = 0;
      reset_n = 1'b1;
      drain(60);
      check_i("frame_beats", pop_count, 9);
      for (int i = 0; i < 9; i++) begin
         check_b($sformatf("frame_last%0d", i + 1), last_hist[i],
                 (i == 3 || i == 7));
      end

      // Random traffic with en and m_ready toggling
      for (int c = 0; c < 1500; c++) begin
         en      = ($urandom_range(0, 9) < 8);
         m_ready = ($urandom_range(0, 9) < 6);
         if (wp < MEM_N - 8 && $urandom_range(0, 2) != 0) push_word();
         cyc_check();
         cyc_adv();
      end
      drain(200);

      // Six pops with three stall cycles after a reset
      reset_n = 1'b0;
      step(1);
      for (int i = 0; i < 6; i++) push_word();
      pop_count = 0;
      en      = 1'b1;
      m_ready = 1'b0;
      reset_n = 1'b1;
      step(5);
      drain(40);
      check_i("stat_seq_pops", pop_count, 6);
`ifdef FIFO_STREAM_DRAIN_STATS_EN
      check_i("stat_seq_beats_total", int'(beats_total), 6);
      check_i("stat_seq_stall_cycles", int'(stall_cycles), 3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
